ni_inject: RTL and testbench

- Network-interface packet injector that drives one router input physical channel: the transmit end of the flit/VC/ready interface that the router input channel receives.
- Accepts a packet descriptor and a payload word stream from the local core and segments them into HEAD/BODY/TAIL (or HEADTAIL) flits.
- Selects an input VC per packet by round-robin and holds that VC for the whole packet (wormhole).
- Sends flits only when the router reports buffer space on the chosen VC.

---
 rtl/ni_inject_pkg.sv | 38 +++
 rtl/ni_vcsel.sv | 40 ++++
 rtl/ni_inject.sv | 151 +++++++++++++++
 tb/tb_ni_inject.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ni_inject_pkg.sv
// Shared definitions for the network-interface packet injector: flit type codes,
// head-flit field positions and the injector state encoding.
package ni_inject_pkg;

    localparam int DATAW  = 32;
    localparam int TYPEW  = 3;
    localparam int ARRAYW = 4;
    localparam int LENW   = 8;
    localparam int VCH    = 2;
    localparam int FLITW  = TYPEW + DATAW;

    localparam logic [TYPEW-1:0] FT_NONE     = 3'd0;
    localparam logic [TYPEW-1:0] FT_HEAD     = 3'd1;
    localparam logic [TYPEW-1:0] FT_BODY     = 3'd2;
    localparam logic [TYPEW-1:0] FT_TAIL     = 3'd3;
    localparam logic [TYPEW-1:0] FT_HEADTAIL = 3'd4;

    // Head flit payload layout
    localparam int DST_LSB = 0;
    localparam int DST_MSB = 7;
    localparam int VCH_POS = 8;
    localparam int SRC_LSB = 9;
    localparam int SRC_MSB = 16;
    localparam int LEN_LSB = 17;
    localparam int LEN_MSB = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_PLD  = 2'd2
    } state_e;

    function automatic logic [FLITW-1:0] mk_flit(input logic [TYPEW-1:0] t,
                                                 input logic [DATAW-1:0] d);
        return {t, d};
    endfunction

endpackage

// File: rtl/ni_vcsel.sv
// Round-robin input-VC picker: prefers the VC at the rr pointer, falls back to the
// other VC, and moves the pointer past the chosen VC when a head is issued.
module ni_vcsel
    import ni_inject_pkg::*;
(
    input  logic           clk,
    input  logic           rst_,
    input  logic [VCH-1:0] irdy,
    input  logic           advance,
    output logic           vc,
    output logic           found
);

    logic rr_q;
    logic rr_d;

    always_comb begin
        vc    = rr_q;
        found = 1'b0;
        rr_d  = rr_q;
        if (irdy[rr_q]) begin
            found = 1'b1;
        end else if (irdy[~rr_q]) begin
            vc    = ~rr_q;
            found = 1'b1;
        end
        if (advance && found) begin
            rr_d = vc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/ni_inject.sv
// Packet injector: segments a descriptor plus payload stream into HEAD/BODY/TAIL
// (or HEADTAIL) flits and drives them onto one router input channel, one VC per packet.
module ni_inject
    import ni_inject_pkg::*;
(
    input  logic                clk,
    input  logic                rst_,
    input  logic [ARRAYW-1:0]   my_xpos,
    input  logic [ARRAYW-1:0]   my_ypos,
    input  logic                pkt_valid,
    output logic                pkt_ready,
    input  logic [2*ARRAYW-1:0] pkt_dst,
    input  logic [LENW-1:0]     pkt_len,
    input  logic                pld_valid,
    input  logic [DATAW-1:0]    pld_data,
    output logic                pld_ready,
    output logic [FLITW-1:0]    odata,
    output logic                ovalid,
    output logic                ovch,
    input  logic [VCH-1:0]      irdy,
    output logic                busy,
    output logic [15:0]         flit_cnt,
    output state_e              dbg_state
);

    state_e                state_q, state_d;
    logic [2*ARRAYW-1:0]   dst_q, dst_d;
    logic [LENW-1:0]       len_q, len_d;
    logic [LENW-1:0]       rem_q, rem_d;
    logic                  vc_q, vc_d;
    logic [FLITW-1:0]      odata_q, odata_d;
    logic                  ovalid_q, ovalid_d;
    logic                  ovch_q, ovch_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  pkt_ready_q, pkt_ready_d;
    logic [DATAW-1:0]      head_w;
    logic                  sel_vc;
    logic                  sel_found;
    logic                  advance;

    ni_vcsel u_vcsel (
        .clk     (clk),
        .rst_    (rst_),
        .irdy    (irdy),
        .advance (advance),
        .vc      (sel_vc),
        .found   (sel_found)
    );

    always_comb begin
        state_d   = state_q;
        dst_d     = dst_q;
        len_d     = len_q;
        rem_d     = rem_q;
        vc_d      = vc_q;
        odata_d   = '0;
        ovalid_d  = 1'b0;
        ovch_d    = ovch_q;
        cnt_d     = cnt_q;
        pld_ready = 1'b0;
        advance   = 1'b0;

        head_w                   = '0;
        head_w[DST_MSB:DST_LSB]  = dst_q;
        head_w[VCH_POS]          = sel_vc;
        head_w[SRC_MSB:SRC_LSB]  = {my_ypos, my_xpos};
        head_w[LEN_MSB:LEN_LSB]  = len_q;

        case (state_q)
            ST_IDLE: begin
                if (pkt_valid && pkt_ready_q) begin
                    dst_d   = pkt_dst;
                    len_d   = pkt_len;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (sel_found) begin
                    advance  = 1'b1;
                    vc_d     = sel_vc;
                    ovalid_d = 1'b1;
                    ovch_d   = sel_vc;
                    rem_d    = len_q;
                    if (len_q == '0) begin
                        odata_d = mk_flit(FT_HEADTAIL, head_w);
                        state_d = ST_IDLE;
                    end else begin
                        odata_d = mk_flit(FT_HEAD, head_w);
                        state_d = ST_PLD;
                    end
                end
            end
            ST_PLD: begin
                // The VC is locked for the packet; the other VC's ready is ignored.
                pld_ready = irdy[vc_q];
                if (pld_valid && irdy[vc_q]) begin
                    ovalid_d = 1'b1;
                    ovch_d   = vc_q;
                    rem_d    = rem_q - LENW'(1);
                    if (rem_q == LENW'(1)) begin
                        odata_d = mk_flit(FT_TAIL, pld_data);
                        state_d = ST_IDLE;
                    end else begin
                        odata_d = mk_flit(FT_BODY, pld_data);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ovalid_d) begin
            cnt_d = cnt_q + 16'd1;
        end
        pkt_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= ST_IDLE;
            dst_q       <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            vc_q        <= 1'b0;
            odata_q     <= '0;
            ovalid_q    <= 1'b0;
            ovch_q      <= 1'b0;
            cnt_q       <= '0;
            pkt_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            vc_q        <= vc_d;
            odata_q     <= odata_d;
            ovalid_q    <= ovalid_d;
            ovch_q      <= ovch_d;
            cnt_q       <= cnt_d;
            pkt_ready_q <= pkt_ready_d;
        end
    end

    assign pkt_ready = pkt_ready_q;
    assign odata     = odata_q;
    assign ovalid    = ovalid_q;
    assign ovch      = ovch_q;
    assign flit_cnt  = cnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ni_inject.sv
// Bench for ni_inject: directed and randomized packets checked cycle by cycle
// against a packet-level model (expected flit queue, round-robin VC, flit count).
module tb_ni_inject;
    import ni_inject_pkg::*;

    logic        clk = 1'b0;
    logic        rst_;
    logic [3:0]  my_xpos, my_ypos;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [7:0]  pkt_dst;
    logic [7:0]  pkt_len;
    logic        pld_valid;
    logic [31:0] pld_data;
    logic        pld_ready;
    logic [34:0] odata;
    logic        ovalid;
    logic        ovch;
    logic [1:0]  irdy;
    logic        busy;
    logic [15:0] flit_cnt;
    state_e      dbg_state;

    ni_inject dut (
        .clk       (clk),
        .rst_      (rst_),
        .my_xpos   (my_xpos),
        .my_ypos   (my_ypos),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_dst   (pkt_dst),
        .pkt_len   (pkt_len),
        .pld_valid (pld_valid),
        .pld_data  (pld_data),
        .pld_ready (pld_ready),
        .odata     (odata),
        .ovalid    (ovalid),
        .ovch      (ovch),
        .irdy      (irdy),
        .busy      (busy),
        .flit_cnt  (flit_cnt),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: expected flits, round-robin pointer, flit count, last VC.
    logic [34:0] exp_q[$];
    int          rr_m;
    logic [15:0] cnt_m;
    logic        last_vc_m;
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_assert++;
        assert (obs === req)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    function automatic logic [34:0] head_flit(input logic [2:0] t, input logic [7:0] dst,
                                              input logic vc, input logic [7:0] len);
        logic [34:0] f;
        f        = '0;
        f[34:32] = t;
        f[7:0]   = dst;
        f[8]     = vc;
        f[12:9]  = my_xpos;
        f[16:13] = my_ypos;
        f[24:17] = len;
        return f;
    endfunction

    // Ends the current cycle and checks what the registered outputs show for it.
    task automatic tick(input bit issue, input logic vc);
        logic [34:0] e_flit;
        e_flit = '0;
        @(posedge clk);
        @(negedge clk);
        if (issue) begin
            cnt_m     = cnt_m + 16'd1;
            last_vc_m = vc;
            if (exp_q.size() > 0) e_flit = exp_q.pop_front();
        end
        chk("ovalid", 64'(ovalid), 64'(issue));
        chk("odata", 64'(odata), 64'(e_flit));
        chk("ovch", 64'(ovch), 64'(last_vc_m));
        chk("flit_cnt", 64'(flit_cnt), 64'(cnt_m));
    endtask

    // pv_mode: 0 = payload always valid, 1 = alternating, 2 = random (irdy random too).
    // head_irdy = 0 randomizes irdy on the head cycle(s).
    task automatic send_pkt(input logic [7:0] dst, input int len, input logic [1:0] head_irdy,
                            input int pv_mode, input int stall_at, input int abort_after);
        int   tries, i, cyc, stall;
        logic chosen;
        bit   go;
        chosen    = 1'b0;
        pkt_valid = 1'b1;
        pkt_dst   = dst;
        pkt_len   = len[7:0];
        pld_valid = 1'b0;
        irdy      = 2'b11;
        #1;
        chk("pkt_ready_idle", 64'(pkt_ready), 64'd1);
        chk("busy_idle", 64'(busy), 64'd0);
        tick(1'b0, 1'b0);
        pkt_valid = 1'b0;
        pkt_dst   = 8'($urandom);
        pkt_len   = 8'($urandom);

        tries = 0;
        while (1) begin
            irdy = (head_irdy != 2'b00) ? head_irdy :
                   (tries < 6) ? 2'($urandom_range(0, 3)) : 2'b11;
            #1;
            chk("busy_head", 64'(busy), 64'd1);
            chk("pkt_ready_busy", 64'(pkt_ready), 64'd0);
            if (irdy != 2'b00) begin
                chosen = irdy[rr_m] ? 1'(rr_m) : 1'(1 - rr_m);
                rr_m   = 1 - int'(chosen);
                exp_q.push_back(head_flit((len == 0) ? FT_HEADTAIL : FT_HEAD, dst, chosen, len[7:0]));
                tick(1'b1, chosen);
                break;
            end
            tick(1'b0, 1'b0);
            tries++;
        end
        if (len == 0) return;

        i = 0; cyc = 0; stall = 0;
        while (i < len) begin
            if (cyc > 300) begin
                chk("payload_timeout", 64'(i), 64'(len));
                break;
            end
            pld_valid = (pv_mode == 0) ? 1'b1 : (pv_mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            if (i == stall_at && stall < 3) begin
                irdy = chosen ? 2'b01 : 2'b10;
                stall++;
            end else begin
                irdy = (pv_mode == 2) ? 2'($urandom_range(0, 3)) : 2'b11;
            end
            pld_data = $urandom;
            go = pld_valid && irdy[chosen];
            #1;
            chk("pld_ready", 64'(pld_ready), 64'(irdy[chosen]));
            if (go) begin
                exp_q.push_back({(i == len - 1) ? FT_TAIL : FT_BODY, pld_data});
                i++;
            end
            tick(go, chosen);
            cyc++;
            if (go && i == abort_after) return;
        end
        pld_valid = 1'b0;
        irdy      = 2'b11;
    endtask

    initial begin
        rr_m      = 0;
        cnt_m     = '0;
        last_vc_m = 1'b0;
        rst_      = 1'b0;
        my_xpos   = 4'd1;
        my_ypos   = 4'd1;
        pkt_valid = 1'b0;
        pkt_dst   = '0;
        pkt_len   = '0;
        pld_valid = 1'b0;
        pld_data  = '0;
        irdy      = 2'b00;

        // Reset state
        #12;
        chk("rst_odata", 64'(odata), 64'd0);
        chk("rst_ovalid", 64'(ovalid), 64'd0);
        chk("rst_ovch", 64'(ovch), 64'd0);
        chk("rst_pkt_ready", 64'(pkt_ready), 64'd0);
        chk("rst_pld_ready", 64'(pld_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_flit_cnt", 64'(flit_cnt), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel_pkt_ready", 64'(pkt_ready), 64'd1);

        // Header-only packet: dst x=2,y=3 from (1,1)
        send_pkt(8'h32, 0, 2'b11, 0, -1, -1);
        chk("ht_low9", 64'(odata[8:0]), 64'h032);
        chk("ht_type", 64'(odata[34:32]), 64'(FT_HEADTAIL));
        chk("ht_state", 64'(dbg_state), 64'(ST_IDLE));

        // Three-word packet, payload held valid
        send_pkt(8'h45, 3, 2'b11, 0, -1, -1);
        chk("cnt_after_3w", 64'(flit_cnt), 64'd5);

        // Backpressure on the packet VC for 3 cycles mid-payload
        send_pkt(8'h17, 5, 2'b11, 0, 2, -1);

        // Round-robin: back-to-back packets, then only VC0 ready at the head
        send_pkt(8'h21, 2, 2'b11, 0, -1, -1);
        send_pkt(8'h12, 1, 2'b11, 0, -1, -1);
        send_pkt(8'h33, 1, 2'b01, 0, -1, -1);
        chk("rr_irdy01_vc", 64'(ovch), 64'd0);

        // Alternating payload-valid bubbles
        send_pkt(8'h56, 4, 2'b11, 1, -1, -1);

        // Randomized packets
        for (int p = 0; p < 25; p++) begin
            my_xpos = 4'($urandom);
            my_ypos = 4'($urandom);
            send_pkt(8'($urandom), int'($urandom_range(0, 6)), 2'b00, 2, -1, -1);
        end

        // Asynchronous reset after one of four payload words
        send_pkt(8'h24, 4, 2'b11, 0, -1, 1);
        #2;
        rst_ = 1'b0;
        #1;
        chk("arst_odata", 64'(odata), 64'd0);
        chk("arst_ovalid", 64'(ovalid), 64'd0);
        chk("arst_ovch", 64'(ovch), 64'd0);
        chk("arst_pkt_ready", 64'(pkt_ready), 64'd0);
        chk("arst_pld_ready", 64'(pld_ready), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_flit_cnt", 64'(flit_cnt), 64'd0);
        chk("arst_state", 64'(dbg_state), 64'(ST_IDLE));
        rr_m      = 0;
        cnt_m     = '0;
        last_vc_m = 1'b0;
        exp_q.delete();
        pld_valid = 1'b0;
        irdy      = 2'b11;
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_pkt_ready", 64'(pkt_ready), 64'd1);
        chk("post_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("post_rst_ovalid", 64'(ovalid), 64'd0);
        send_pkt(8'h61, 2, 2'b11, 0, -1, -1);
        chk("post_rst_cnt", 64'(flit_cnt), 64'd3);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
